conv1d_seq_mac: RTL
===================

Name: conv1d_seq_mac

Overview:
- Parametrised, multi-cycle successor to the fixed 4x4 packed-operand 1-D convolution unit in the RISC-V CNN accelerator datapath.
- Computes the full linear convolution y[k] = sum x[i]*h[j] over all i+j=k, for N-element sample and kernel vectors.
- Uses one shared MAC, time-multiplexed by a small FSM.
- Adds signed/unsigned mode and saturating output, and is driven by a start/done handshake from the core's custom-instruction issue logic.

Parameters:
- N, 4, elements per operand vector (N >= 2).
- DATA_W, 8, bits per x/h element.
- OUT_W, 16, bits per result element (OUT_W <= ACC_W).
- ACC_W, 2*DATA_W+$clog2(N), internal accumulator width. Derived; do not override.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- signed_mode  input  1  1 = operands and results two's complement; captured with start.
- x_vec  input  N*DATA_W  samples; x[i] at bits [i*DATA_W +: DATA_W]; captured with start.
- h_vec  input  N*DATA_W  kernel; h[j] at bits [j*DATA_W +: DATA_W]; captured with start.
- busy  output  1  high while computing.
- done  output  1  one-cycle pulse when result is updated.
- result  output  (2N-1)*OUT_W  y[k] at bits [k*OUT_W +: OUT_W]; held until next done.

Behaviour:
- Reset (async assert, sync deassert handled upstream): state=IDLE; busy=0; done=0; result=0; accumulators, indices and operand registers = 0.
- Reset mid-operation aborts the computation. No done is produced.
- States: IDLE, MAC, FINAL.
- IDLE:
  - start=1 at edge T: capture x_vec, h_vec, signed_mode; clear all 2N-1 accumulators; i=j=0; go to MAC.
  - busy=1 from T+1.
- MAC:
  - One product per cycle: acc[i+j] += ext(x[i])*ext(h[j]).
  - ext = sign-extension when signed_mode=1, zero-extension otherwise.
  - Iteration order: j inner, i outer, both 0..N-1.
  - After (i,j)=(N-1,N-1), go to FINAL. Exactly N*N MAC cycles.
- FINAL:
  - Each acc[k] is clamped into OUT_W and written to result.
  - Unsigned clamp range: [0, 2^OUT_W-1].
  - Signed clamp range: [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - No clamp is applied when OUT_W == ACC_W.
  - done=1 for this single cycle; busy=0 next cycle; return to IDLE.
- Latency: start at edge T -> done high in cycle T+N*N+1 (T+17 for N=4). result valid from the same cycle.
- start while busy (MAC/FINAL) is ignored; operand registers are not disturbed.
- start asserted in the cycle after done is accepted (back-to-back). There is no IDLE dwell requirement.
- Accumulators never overflow: ACC_W covers N full-scale products in both modes.
- busy and done are never high together.

Decomposition:
- Package conv_pkg:
  - state enum {IDLE, MAC, FINAL};
  - function clamp_acc(acc, signed_mode) parametrised on ACC_W/OUT_W;
  - localparam N_OUT = 2*N-1.
- One sub-module, conv_mac: combinational ext/multiply/add, producing acc_in + x*h at ACC_W with mode select. It is instantiated once.

Test Plan:
- Unsigned basic, N=4, DATA_W=8, OUT_W=16: x=[1,2,3,4], h=[1,1,1,1] -> result y0..y6 = [1,3,6,10,9,7,4]; done exactly 17 cycles after start; busy high 16 cycles.
- Unsigned saturation: x=h=[255,255,255,255] -> y0=65025, y1=65535 (130050 clamped), y2..y4=65535, y5=65535, y6=65025.
- Signed: x=[-128,0,0,0], h=[-128,0,0,0] -> y0=16384, all others 0. Signed negative clamp: x=[-128]*4, h=[127]*4 -> y3=-32768 (−65024 clamped), y0=y6=-16256.
- start pulsed again at cycle T+5 with different operands -> ignored; first result unchanged; second start immediately after done -> accepted, new result after 17 cycles.
- rst_n low at cycle T+8 -> busy, done, result = 0 immediately (async). No done pulse afterwards. A fresh start completes normally.
- Parameter sweep N=2, DATA_W=4, OUT_W=ACC_W=9: x=[15,15], h=[15,15] -> y=[225,450,225], latency 5 cycles.

Source files
------------

// File: rtl/conv1d_seq_mac_pkg.sv
// Shared types and helpers for the sequential 1-D convolution unit.
// Holds the FSM state encoding, the output-count helper and the accumulator clamp.
package conv_pkg;

    typedef enum logic [1:0] {IDLE, MAC, FINAL} state_t;

    // Number of result elements of a full linear convolution of two n-vectors.
    function automatic int n_out(input int n);
        return 2 * n - 1;
    endfunction

    // acc arrives already sign/zero-extended to 64 bits by the caller.
    function automatic longint clamp_acc(input longint acc, input logic signed_mode,
                                         input int acc_w, input int out_w);
        longint hi;
        longint lo;
        longint r;
        hi = 0;
        lo = 0;
        r  = acc;
        if (out_w < acc_w) begin
            if (signed_mode) begin
                hi = (longint'(1) <<< (out_w - 1)) - 1;
                lo = -hi - 1;
            end else begin
                hi = (longint'(1) <<< out_w) - 1;
                lo = 0;
            end
            if (acc > hi) begin
                r = hi;
            end else if (acc < lo) begin
                r = lo;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/conv1d_seq_mac_mac.sv
// Single shared multiply-accumulate: acc_out = acc_in + ext(x) * ext(h).
// Both operands are extended to ACC_W so the low ACC_W product bits are exact in either mode.
module conv_mac #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 18
) (
    input  logic              signed_mode,
    input  logic [DATA_W-1:0] x,
    input  logic [DATA_W-1:0] h,
    input  logic [ACC_W-1:0]  acc_in,
    output logic [ACC_W-1:0]  acc_out
);

    logic [ACC_W-1:0] x_ext;
    logic [ACC_W-1:0] h_ext;
    logic [ACC_W-1:0] prod;

    always_comb begin
        x_ext   = {{(ACC_W-DATA_W){signed_mode & x[DATA_W-1]}}, x};
        h_ext   = {{(ACC_W-DATA_W){signed_mode & h[DATA_W-1]}}, h};
        prod    = x_ext * h_ext;
        acc_out = acc_in + prod;
    end

endmodule

// File: rtl/conv1d_seq_mac.sv
// Multi-cycle full linear convolution of two N-element vectors using one shared MAC.
// One product per cycle (j inner, i outer), then one cycle to clamp and publish the result.
module conv1d_seq_mac
    import conv_pkg::*;
#(
    parameter int N      = 4,
    parameter int DATA_W = 8,
    parameter int OUT_W  = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         signed_mode,
    input  logic [N*DATA_W-1:0]          x_vec,
    input  logic [N*DATA_W-1:0]          h_vec,
    output logic                         busy,
    output logic                         done,
    output logic [(2*N-1)*OUT_W-1:0]     result
);

    localparam int ACC_W = 2 * DATA_W + $clog2(N);
    localparam int N_OUT = n_out(N);
    localparam int IW    = $clog2(N);
    localparam int KW    = $clog2(N_OUT);

    state_t                   state_q;
    logic [IW-1:0]            i_q;
    logic [IW-1:0]            j_q;
    logic [DATA_W-1:0]        x_q [N];
    logic [DATA_W-1:0]        h_q [N];
    logic                     sm_q;
    logic [ACC_W-1:0]         acc_q [N_OUT];
    logic [N_OUT*OUT_W-1:0]   result_q;
    logic                     busy_q;
    logic                     done_q;

    logic [KW-1:0]            k_idx;
    logic [ACC_W-1:0]         mac_out;
    logic [N_OUT*OUT_W-1:0]   clamp_w;

    assign k_idx = KW'(i_q) + KW'(j_q);

    conv_mac #(
        .DATA_W(DATA_W),
        .ACC_W (ACC_W)
    ) u_mac (
        .signed_mode(sm_q),
        .x          (x_q[i_q]),
        .h          (h_q[j_q]),
        .acc_in     (acc_q[k_idx]),
        .acc_out    (mac_out)
    );

    for (genvar gi = 0; gi < N_OUT; gi++) begin : g_clamp
        logic signed [63:0] acc_sx;
        longint             clamped;
        logic               unused_clamp_hi;

        always_comb begin
            acc_sx  = {{(64-ACC_W){sm_q & acc_q[gi][ACC_W-1]}}, acc_q[gi]};
            clamped = clamp_acc(acc_sx, sm_q, ACC_W, OUT_W);
        end

        assign clamp_w[gi*OUT_W +: OUT_W] = clamped[OUT_W-1:0];
        assign unused_clamp_hi            = ^clamped[63:OUT_W];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            i_q      <= '0;
            j_q      <= '0;
            sm_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            for (int n = 0; n < N; n++) begin
                x_q[n] <= '0;
                h_q[n] <= '0;
            end
            for (int k = 0; k < N_OUT; k++) begin
                acc_q[k] <= '0;
            end
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        sm_q <= signed_mode;
                        for (int n = 0; n < N; n++) begin
                            x_q[n] <= x_vec[n*DATA_W +: DATA_W];
                            h_q[n] <= h_vec[n*DATA_W +: DATA_W];
                        end
                        for (int k = 0; k < N_OUT; k++) begin
                            acc_q[k] <= '0;
                        end
                        i_q     <= '0;
                        j_q     <= '0;
                        busy_q  <= 1'b1;
                        state_q <= MAC;
                    end
                end
                MAC: begin
                    acc_q[k_idx] <= mac_out;
                    if (j_q == IW'(N-1)) begin
                        j_q <= '0;
                        if (i_q == IW'(N-1)) begin
                            // busy drops before the publish cycle so it never overlaps done
                            i_q     <= '0;
                            busy_q  <= 1'b0;
                            state_q <= FINAL;
                        end else begin
                            i_q <= i_q + 1'b1;
                        end
                    end else begin
                        j_q <= j_q + 1'b1;
                    end
                end
                FINAL: begin
                    result_q <= clamp_w;
                    done_q   <= 1'b1;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule
